// File: rtl/can_pkg.sv
// Shared CAN fault-confinement types and default limits.
package can_pkg;

    typedef enum logic [1:0] {
        FC_ACTIVE  = 2'd0,
        FC_PASSIVE = 2'd1,
        FC_BUSOFF  = 2'd2
    } fc_state_t;

    localparam int DEF_WARN_LIMIT   = 96;
    localparam int DEF_PASSIVE_LIMIT = 128;
    localparam int DEF_BUSOFF_LIMIT = 256;
    localparam int DEF_RECOV_SEQ    = 128;
    localparam int DEF_RECOV_BITS   = 11;
    localparam int DEF_AUTO_RECOVER = 1;

endpackage

// File: rtl/can_busoff_recovery.sv
// Bus-off recovery: counts runs of recessive bits and completed sequences while enabled.
module can_busoff_recovery
    import can_pkg::*;
#(
    parameter int RECOV_SEQ    = DEF_RECOV_SEQ,
    parameter int RECOV_BITS   = DEF_RECOV_BITS,
    parameter int AUTO_RECOVER = DEF_AUTO_RECOVER
) (
    input  logic       clk_can,
    input  logic       rst,
    input  logic       en,
    input  logic       bit_tick,
    input  logic       rx_bit,
    input  logic       recover_req,
    output logic [7:0] recov_cnt,
    output logic       done
);

    logic [15:0] run_r;
    logic [7:0]  seq_r;
    logic        req_r;
    logic        counting_s;
    logic        run_full_s;
    logic        done_s;

    // Decode whether this tick closes the final recessive sequence
    always_comb begin
        counting_s = 1'b0;
        run_full_s = 1'b0;
        done_s     = 1'b0;
        if (en) begin
            counting_s = (AUTO_RECOVER != 0) || req_r;
        end else begin
            counting_s = 1'b0;
        end
        run_full_s = (int'(run_r) == RECOV_BITS - 1);
        if (counting_s && bit_tick && rx_bit && run_full_s) begin
            done_s = (int'(seq_r) == RECOV_SEQ - 1);
        end else begin
            done_s = 1'b0;
        end
    end

    // Run/sequence counters and request latch; all held clear outside bus-off
    always_ff @(posedge clk_can or posedge rst) begin
        if (rst) begin
            run_r <= 16'd0;
            seq_r <= 8'd0;
            req_r <= 1'b0;
        end else if (!en || done_s) begin
            run_r <= 16'd0;
            seq_r <= 8'd0;
            req_r <= 1'b0;
        end else begin
            if (recover_req) begin
                req_r <= 1'b1;
            end
            if (counting_s && bit_tick) begin
                if (!rx_bit) begin
                    run_r <= 16'd0;
                end else if (run_full_s) begin
                    run_r <= 16'd0;
                    if (seq_r != 8'hFF) begin
                        seq_r <= seq_r + 8'd1;
                    end
                end else begin
                    run_r <= run_r + 16'd1;
                end
            end
        end
    end

    assign recov_cnt = seq_r;
    assign done      = done_s;

endmodule

// File: rtl/can_fault_confinement.sv
// CAN error counters (TEC/REC) with active/passive/bus-off confinement and recovery.
module can_fault_confinement
    import can_pkg::*;
#(
    parameter int WARN_LIMIT    = DEF_WARN_LIMIT,
    parameter int PASSIVE_LIMIT = DEF_PASSIVE_LIMIT,
    parameter int BUSOFF_LIMIT  = DEF_BUSOFF_LIMIT,
    parameter int RECOV_SEQ     = DEF_RECOV_SEQ,
    parameter int RECOV_BITS    = DEF_RECOV_BITS,
    parameter int AUTO_RECOVER  = DEF_AUTO_RECOVER
) (
    input  logic       clk_can,
    input  logic       rst,
    input  logic       bit_tick,
    input  logic       rx_bit,
    input  logic       tx_err_ev,
    input  logic       tx_ok_ev,
    input  logic       rx_err_ev,
    input  logic       rx_err_dom_ev,
    input  logic       rx_ok_ev,
    input  logic       recover_req,
    output logic [8:0] tec,
    output logic [7:0] rec,
    output logic [1:0] fc_state,
    output logic       err_warn,
    output logic       tx_enable,
    output logic       state_chg_irq,
    output logic [7:0] recov_cnt
);

    fc_state_t   state_r, state_nxt_s;
    logic [8:0]  tec_r, tec_nxt_s;
    logic [9:0]  tec_sum_s;
    logic [7:0]  rec_r, rec_nxt_s;
    logic [8:0]  rec_sum_s;
    logic        warn_r, warn_nxt_s;
    logic        txen_r;
    logic        irq_r;
    logic        busoff_s;
    logic        rcv_done_s;

    assign busoff_s = (state_r == FC_BUSOFF);

    can_busoff_recovery #(
        .RECOV_SEQ   (RECOV_SEQ),
        .RECOV_BITS  (RECOV_BITS),
        .AUTO_RECOVER(AUTO_RECOVER)
    ) u_recovery (
        .clk_can    (clk_can),
        .rst        (rst),
        .en         (busoff_s),
        .bit_tick   (bit_tick),
        .rx_bit     (rx_bit),
        .recover_req(recover_req),
        .recov_cnt  (recov_cnt),
        .done       (rcv_done_s)
    );

    // Next counter values and confinement state; bus-off freezes counters until recovery
    always_comb begin
        tec_sum_s   = {1'b0, tec_r} + 10'd8;
        rec_sum_s   = {1'b0, rec_r} + (rx_err_ev ? 9'd1 : 9'd0) + (rx_err_dom_ev ? 9'd8 : 9'd0);
        tec_nxt_s   = tec_r;
        rec_nxt_s   = rec_r;
        state_nxt_s = state_r;
        if (busoff_s) begin
            if (rcv_done_s) begin
                tec_nxt_s   = 9'd0;
                rec_nxt_s   = 8'd0;
                state_nxt_s = FC_ACTIVE;
            end else begin
                state_nxt_s = FC_BUSOFF;
            end
        end else begin
            if (tx_err_ev) begin
                tec_nxt_s = (int'(tec_sum_s) >= BUSOFF_LIMIT) ? 9'(BUSOFF_LIMIT) : tec_sum_s[8:0];
            end else if (tx_ok_ev && (tec_r != 9'd0)) begin
                tec_nxt_s = tec_r - 9'd1;
            end else begin
                tec_nxt_s = tec_r;
            end
            // Error events outrank a successful reception in the same cycle
            if (rx_err_ev || rx_err_dom_ev) begin
                rec_nxt_s = rec_sum_s[8] ? 8'hFF : rec_sum_s[7:0];
            end else if (rx_ok_ev) begin
                if (int'(rec_r) >= PASSIVE_LIMIT) begin
                    rec_nxt_s = 8'(PASSIVE_LIMIT - 9);
                end else if (rec_r != 8'd0) begin
                    rec_nxt_s = rec_r - 8'd1;
                end else begin
                    rec_nxt_s = rec_r;
                end
            end else begin
                rec_nxt_s = rec_r;
            end
            if (int'(tec_nxt_s) >= BUSOFF_LIMIT) begin
                state_nxt_s = FC_BUSOFF;
            end else if ((int'(tec_nxt_s) >= PASSIVE_LIMIT) || (int'(rec_nxt_s) >= PASSIVE_LIMIT)) begin
                state_nxt_s = FC_PASSIVE;
            end else begin
                state_nxt_s = FC_ACTIVE;
            end
        end
        warn_nxt_s = ((int'(tec_nxt_s) >= WARN_LIMIT) || (int'(rec_nxt_s) >= WARN_LIMIT))
                     && (state_nxt_s != FC_BUSOFF);
    end

    // Registered counters, state and status flags
    always_ff @(posedge clk_can or posedge rst) begin
        if (rst) begin
            tec_r   <= 9'd0;
            rec_r   <= 8'd0;
            state_r <= FC_ACTIVE;
            warn_r  <= 1'b0;
            txen_r  <= 1'b1;
            irq_r   <= 1'b0;
        end else begin
            tec_r   <= tec_nxt_s;
            rec_r   <= rec_nxt_s;
            state_r <= state_nxt_s;
            warn_r  <= warn_nxt_s;
            txen_r  <= (state_nxt_s != FC_BUSOFF);
            irq_r   <= (state_nxt_s != state_r);
        end
    end

    assign tec           = tec_r;
    assign rec           = rec_r;
    assign fc_state      = state_r;
    assign err_warn      = warn_r;
    assign tx_enable     = txen_r;
    assign state_chg_irq = irq_r;

endmodule
